riscv_fetch_queue: RTL and testbench
====================================

// Module: riscv_fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end for the RISC-V pipeline. Generalises in-order PC+4 fetch to a
//  variable-latency imem with valid/ready on request and response, a DEPTH-entry prefetch queue, and
//  redirect with flush and stale-response drop. Sits between imem and the IF/ID register; decode pulls via fe_*.
// PARAMETERS
//  XLEN      64  width of PC and addresses (32 or 64)
//  DEPTH     4   prefetch queue entries; power of 2, >=2
//  RESET_PC  0   PC fetched first after reset
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     synchronous reset, active-low
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request
//  imem_req_addr   out  XLEN  fetch address, bits[1:0]=0
//  imem_rsp_valid  in   1     response valid; responses return in request order, no backpressure
//  imem_rsp_instr  in   32    fetched instruction
//  redirect_valid  in   1     jump/branch redirect, single-cycle pulse
//  redirect_pc     in   XLEN  redirect target; bits[1:0] ignored (forced 0)
//  fe_valid        out  1     queue head valid toward decode
//  fe_ready        in   1     decode accepts head
//  fe_pc           out  XLEN  PC of head instruction
//  fe_instr        out  32    head instruction
//  halt            out  1     sticky: halt instruction 32'h0000006F handed to decode
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; halt=0.
//   Outputs during/after reset: imem_req_valid=0, fe_valid=0, halt=0; fe_pc/fe_instr=0 while empty.
//   Reset mid-operation discards queue, outstanding and drop count; later responses for
//   pre-reset requests are the memory's responsibility (imem is reset together).
//  Request issue: imem_req_valid = !halt && !redirect_valid && (count + outstanding) < DEPTH.
//   imem_req_addr = fetch_pc. On req handshake: fetch_pc += 4 (mod 2^XLEN wrap), outstanding++.
//   Slot reservation guarantees each response finds a free queue entry; no response is ever lost.
//  Response: imem_rsp_valid with drop_cnt>0 -> discard, drop_cnt--, outstanding--.
//   Otherwise enqueue {pc, instr} (pc from a parallel in-order PC FIFO or head-PC counter),
//   outstanding--. Entry visible on fe_valid the cycle AFTER the response (registered queue).
//  Dequeue: fe_valid && fe_ready pops head. Enqueue and dequeue in the same cycle: count unchanged.
//   Full (count==DEPTH): no request possible (reservation rule); fe_valid stays 1 until popped.
//   Empty: fe_valid=0; fe_pc/fe_instr hold don't-care, bench must not check them.
//  Redirect (priority over all else in that cycle):
//   queue flushed (count=0), pop in that cycle ignored, fe_valid=0 next cycle;
//   fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; halt cleared; no request issued that cycle;
//   drop_cnt <= outstanding minus any non-dropped response arriving that cycle (that response is
//   itself discarded); stale responses dropped in order; new requests allowed from the next cycle.
//   Minimum redirect-to-fe_valid latency with zero-wait imem: 3 cycles (req N+1, rsp N+2, valid N+3).
//  Halt: on pop of instr==32'h0000006F, halt<=1 next cycle; while halt=1 no new requests,
//   queued/in-flight entries still drain to decode. Cleared only by redirect or reset.
//  Counters: count, outstanding sized $clog2(DEPTH)+1; never exceed DEPTH (assertion).
//  Throughput: one instruction per cycle sustained when imem is zero-wait and fe_ready=1.
// TESTING
//  1 Reset then zero-wait imem returning addr-as-data, fe_ready=1 -> fe_pc 0,4,8,12.. one per cycle,
//    first fe_valid 2 cycles after first req handshake.
//  2 fe_ready=0 for 10 cycles -> exactly DEPTH(4) requests issued, queue full, imem_req_valid=0;
//    release -> PCs 0,4,8,12,16 in order with no gap or duplicate.
//  3 imem latency 3 with 3 in flight, redirect_pc=0x1003 -> 3 stale responses dropped, next fe_pc=0x1000,
//    no instruction from old stream ever presented.
//  4 Redirect in same cycle as response and fe_ready pop -> response discarded, pop ignored,
//    fe_valid=0 next cycle.
//  5 Memory word 0x0000006F at PC 0x8 -> halt=1 cycle after its pop, no further requests;
//    redirect to 0x40 clears halt and fetch resumes at 0x40.
//  6 XLEN=32, redirect_pc=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000 (wrap).
//  7 rst_n low for 1 cycle mid-stream with 2 in flight -> all outputs 0 next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_queue_if.sv
// Fetch-unit bundle between the instruction fetch queue, the imem and decode.
//   imem request  : imem_req_valid/imem_req_ready/imem_req_addr
//   imem response : imem_rsp_valid/imem_rsp_instr (in order, never stalled)
//   redirect      : redirect_valid/redirect_pc (single-cycle pulse)
//   decode side   : fe_valid/fe_ready/fe_pc/fe_instr, sticky halt
// modport master : the fetch queue itself
// modport slave  : the surrounding imem/decode/branch logic
interface riscv_fetch_queue_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fe_valid;
  logic            fe_ready;
  logic [XLEN-1:0] fe_pc;
  logic [31:0]     fe_instr;
  logic            halt;

  modport master (
    output imem_req_valid, imem_req_addr, fe_valid, fe_pc, fe_instr, halt,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_instr,
    input  redirect_valid, redirect_pc, fe_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fe_valid, fe_pc, fe_instr, halt,
    output imem_req_ready, imem_rsp_valid, imem_rsp_instr,
    output redirect_valid, redirect_pc, fe_ready
  );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: issues sequential PC+4 fetches to a
// variable-latency imem, buffers responses in a DEPTH-entry queue toward
// decode, and handles redirects by flushing the queue and dropping the
// responses of requests that were already in flight.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : riscv_fetch_queue_if.master (imem request/response, redirect,
//           decode handshake, sticky halt)
module riscv_fetch_queue #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_fetch_queue_if.master  bus
);

  localparam int unsigned   AW         = $clog2(DEPTH);
  localparam int unsigned   CW         = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [31:0]   HALT_INSTR = 32'h0000_006F;

  function automatic logic [CW-1:0] step_cnt(input logic [CW-1:0] v,
                                             input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   step_cnt = v + CW'(1);
      2'b01:   step_cnt = v - CW'(1);
      default: step_cnt = v;
    endcase
  endfunction

  logic [XLEN-1:0] fetch_pc;
  // PC of the next response that will be kept; responses come back in
  // request order, so this tracks the queue-side PC without a side FIFO.
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            halt_q;

  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];

  logic [CW:0]     slots_used;
  logic            head_valid;
  logic            req_fire;
  logic            rsp_drop;
  logic            enq;
  logic            pop;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsb;

  assign redirect_target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Queued entries plus in-flight requests must fit the queue, so every
  // response is guaranteed a free slot when it lands.
  assign slots_used = {1'b0, count} + {1'b0, outstanding};
  assign head_valid = (count != '0);

  assign bus.imem_req_valid = rst_n && !halt_q && !bus.redirect_valid &&
                              (slots_used < {1'b0, DEPTH_C});
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_drop = bus.imem_rsp_valid && (drop_cnt != '0);
  assign enq      = bus.imem_rsp_valid && (drop_cnt == '0);

  assign bus.fe_valid = rst_n && head_valid;
  assign bus.fe_pc    = head_valid ? q_pc[rd_ptr]    : '0;
  assign bus.fe_instr = head_valid ? q_instr[rd_ptr] : '0;
  assign bus.halt     = rst_n && halt_q;
  assign pop          = bus.fe_valid && bus.fe_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      halt_q      <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight belongs to the old stream; a response
      // landing right now is discarded as well, so it leaves the count.
      fetch_pc    <= redirect_target;
      rsp_pc      <= redirect_target;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= step_cnt(outstanding, 1'b0, bus.imem_rsp_valid);
      drop_cnt    <= step_cnt(outstanding, 1'b0, bus.imem_rsp_valid);
      halt_q      <= 1'b0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      outstanding <= step_cnt(outstanding, req_fire, bus.imem_rsp_valid);
      drop_cnt    <= step_cnt(drop_cnt, 1'b0, rsp_drop);
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        if (q_instr[rd_ptr] == HALT_INSTR) begin
          halt_q <= 1'b1;
        end
      end
      count <= step_cnt(count, enq, pop);
    end
  end

  // Queue storage carries data only; validity lives in count/pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= rsp_pc;
      q_instr[wr_ptr] <= bus.imem_rsp_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= DEPTH_C);
      assert (outstanding <= DEPTH_C);
      assert (slots_used <= {1'b0, DEPTH_C});
    end
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: an in-order fixed-latency imem responder,
// a scoreboard of expected {pc, instr} pushed as responses are handed to
// the DUT and popped as decode accepts them, plus directed scenarios.
module tb_riscv_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fe_item_t;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
    bit              stale;
  } pend_t;

  logic clk;
  logic rst_n;

  riscv_fetch_queue_if #(.XLEN(XLEN)) bus ();

  riscv_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  fe_item_t        sb[$];
  pend_t           pend[$];
  int              cyc = 0;
  int              lat = 1;
  bit              halt_en = 1'b0;
  logic [XLEN-1:0] halt_addr = '0;
  logic [XLEN-1:0] cur_addr = '0;
  bit              cur_stale = 1'b0;
  logic [XLEN-1:0] exp_req_pc = '0;
  int              req_cnt = 0;
  int              pop_cnt = 0;
  int              stale_drops = 0;
  int              first_req = -1;
  int              first_val = -1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    if (halt_en && a == halt_addr) return 32'h0000_006F;
    return 32'(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max, output int n);
    n = 0;
    @(negedge clk);
    while (!bus.fe_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.fe_valid, 1);
  endtask

  // imem responder: one response per cycle, strictly in request order
  initial begin
    pend_t p;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_instr = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_instr = mem_word(p.addr);
        cur_addr  = p.addr;
        cur_stale = p.stale;
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
    end
  end

  // monitor: scoreboard pops, response bookkeeping, request address model
  always @(negedge clk) begin
    fe_item_t e;
    pend_t    np;
    if (!rst_n) begin
      pend.delete();
      sb.delete();
      exp_req_pc  = '0;
      req_cnt     = 0;
      pop_cnt     = 0;
      stale_drops = 0;
      first_req   = -1;
      first_val   = -1;
    end else begin
      if (bus.fe_valid && first_val < 0) first_val = cyc;
      if (bus.fe_valid && bus.fe_ready && !bus.redirect_valid) begin
        pop_cnt++;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_pc", bus.fe_pc, e.pc);
          check("sb_instr", bus.fe_instr, e.instr);
        end
      end
      if (bus.redirect_valid) begin
        sb.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_req_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
        if (bus.imem_rsp_valid) stale_drops++;
      end else if (bus.imem_rsp_valid) begin
        if (cur_stale) stale_drops++;
        else sb.push_back({cur_addr, bus.imem_rsp_instr});
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("req_addr", bus.imem_req_addr, exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
        np.addr  = bus.imem_req_addr;
        np.due   = cyc + lat;
        np.stale = 1'b0;
        pend.push_back(np);
        req_cnt++;
        if (first_req < 0) first_req = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run got stuck, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_redirect(input logic [XLEN-1:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    bus.fe_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    rst_n              = 1'b0;
    repeat (ncyc) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int p0;
    int r0;
    rst_n              = 1'b0;
    bus.fe_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;

    // 1: reset state, streaming, first-valid latency, throughput, random stalls
    step();
    @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_fe_valid", bus.fe_valid, 0);
    check("rst_halt", bus.halt, 0);
    check("rst_fe_pc", bus.fe_pc, 0);
    check("rst_fe_instr", bus.fe_instr, 0);
    step();
    rst_n = 1'b1;
    bus.fe_ready = 1'b1;
    repeat (12) step();
    check("t1_first_latency", first_val - first_req, 2);
    p0 = pop_cnt;
    repeat (8) step();
    check("t1_throughput", pop_cnt - p0, 8);
    repeat (30) begin
      step();
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.fe_ready       = 1'($urandom_range(0, 1));
    end
    bus.imem_req_ready = 1'b1;
    bus.fe_ready       = 1'b1;
    repeat (10) step();

    // 2: decode stalled -> queue fills with exactly DEPTH requests
    do_reset(1);
    repeat (10) step();
    check("t2_req_count", req_cnt, DEPTH);
    @(negedge clk);
    check("t2_req_blocked", bus.imem_req_valid, 0);
    check("t2_full_valid", bus.fe_valid, 1);
    check("t2_head_pc", bus.fe_pc, 0);
    step();
    bus.fe_ready = 1'b1;
    p0 = pop_cnt;
    repeat (8) step();
    check("t2_no_gap", pop_cnt - p0, 8);

    // 3: latency-3 imem, redirect with three requests in flight
    lat = 3;
    do_reset(1);
    bus.fe_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    #1;
    check("t3_inflight", pend.size(), 3);
    step();
    pulse_redirect(32'h1003);
    wait_valid("t3_valid_timeout", 20, n);
    check("t3_first_pc", bus.fe_pc, 32'h1000);
    check("t3_first_instr", bus.fe_instr, 32'h1000);
    step();
    repeat (6) step();
    check("t3_stale_drops", stale_drops, 3);
    lat = 1;
    repeat (10) step();

    // 4: redirect coinciding with a response and a pop
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    @(negedge clk);
    check("t4_rsp_same_cycle", bus.imem_rsp_valid, 1);
    check("t4_pop_same_cycle", bus.fe_valid, 1);
    step();
    bus.redirect_valid = 1'b0;
    wait_valid("t4_valid_timeout", 20, n);
    check("t4_redirect_latency", n + 1, 3);
    check("t4_first_pc", bus.fe_pc, 32'h200);
    step();

    // 5: halt instruction at 0x8, then redirect to 0x40
    halt_en   = 1'b1;
    halt_addr = 32'h8;
    do_reset(1);
    bus.fe_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bus.fe_valid && bus.fe_ready && bus.fe_instr == 32'h6F) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t5_halt_seen", n < 40, 1);
    check("t5_halt_before_pop", bus.halt, 0);
    @(negedge clk);
    check("t5_halt_set", bus.halt, 1);
    check("t5_req_stopped", bus.imem_req_valid, 0);
    step();
    r0 = req_cnt;
    repeat (10) step();
    check("t5_no_new_req", req_cnt, r0);
    check("t5_halt_sticky", bus.halt, 1);
    check("t5_drained", bus.fe_valid, 0);
    halt_en = 1'b0;
    pulse_redirect(32'h40);
    @(negedge clk);
    check("t5_halt_cleared", bus.halt, 0);
    check("t5_resume_req", bus.imem_req_valid, 1);
    check("t5_resume_addr", bus.imem_req_addr, 32'h40);
    wait_valid("t5_valid_timeout", 20, n);
    check("t5_resume_pc", bus.fe_pc, 32'h40);
    repeat (6) step();

    // 6: fetch address wraps at 2^XLEN
    pulse_redirect(32'hFFFF_FFFC);
    @(negedge clk);
    check("t6_req_top", bus.imem_req_addr, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("t6_req_wrap", bus.imem_req_addr, 32'h0);
    step();
    @(negedge clk);
    check("t6_fe_top", bus.fe_pc, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    check("t6_fe_wrap", bus.fe_pc, 32'h0);
    repeat (5) step();

    // 7: one-cycle reset mid-stream with two requests in flight
    lat = 2;
    repeat (10) step();
    @(negedge clk);
    #1;
    check("t7_inflight", pend.size(), 2);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_rst_req_valid", bus.imem_req_valid, 0);
    check("t7_rst_fe_valid", bus.fe_valid, 0);
    check("t7_rst_halt", bus.halt, 0);
    step();
    rst_n = 1'b1;
    lat = 1;
    @(negedge clk);
    check("t7_post_fe_valid", bus.fe_valid, 0);
    check("t7_post_halt", bus.halt, 0);
    check("t7_post_fe_pc", bus.fe_pc, 0);
    check("t7_post_fe_instr", bus.fe_instr, 0);
    check("t7_restart_addr", bus.imem_req_addr, 32'h0);
    step();
    repeat (10) step();
    check("t7_stream_resumed", pop_cnt > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
